m_hazard_unit: RTL and testbench

Parametrised hazard-detection and forwarding-control block for the pipelined MIPS-subset processor family. It sits beside the ID stage and tracks every in-flight register write in a configurable number of downstream stages. Each cycle it produces, combinationally, a per-source-operand forwarding select and a load-use stall for the instruction in ID. It replaces hand-written per-operand forwarding comparators with one scoreboard that generalises register count, operand count, pipeline depth and load latency.

---
 rtl/m_hazard_unit_pkg.sv | 26 ++
 rtl/m_hazard_unit_fwd_match.sv | 34 +++
 rtl/m_hazard_unit.sv | 91 +++++++++
 tb/tb_m_hazard_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/m_hazard_unit_pkg.sv
// Shared pipeline definitions: opcodes, scoreboard entry, forwarding encoding.
package pkg_pipe;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h11;

  // Destination field is sized for the widest supported register index;
  // narrower register files store their index zero-extended.
  localparam int unsigned RD_MAXW = 8;

  typedef struct packed {
    logic               valid;
    logic [RD_MAXW-1:0] rd;
    logic               we;
    logic               ld;
  } sb_entry_t;

  // Select value meaning "read the register file".
  localparam int unsigned FWD_RF = 0;

endpackage

// File: rtl/m_hazard_unit_fwd_match.sv
// Priority match of one source operand against all tracked stages.
module m_fwd_match
  import pkg_pipe::*;
#(
  parameter int unsigned REGW    = 5,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned LDAVAIL = 3,
  parameter int unsigned SELW    = 2
) (
  input  sb_entry_t [STAGES-1:0] i_sb,
  input  logic [REGW-1:0]        i_src,
  input  logic                   i_use,
  output logic [SELW-1:0]        o_sel,
  output logic                   o_hazard
);

  logic [RD_MAXW-1:0] w_src_ext;

  assign w_src_ext = RD_MAXW'(i_src);

  // Scan oldest to youngest so the youngest matching writer overrides.
  always_comb begin
    o_sel    = SELW'(FWD_RF);
    o_hazard = 1'b0;
    for (int unsigned k = STAGES; k >= 1; k--) begin
      if (i_use && (i_src != '0) && i_sb[k-1].valid && i_sb[k-1].we &&
          (i_sb[k-1].rd == w_src_ext)) begin
        o_sel    = SELW'(k);
        o_hazard = i_sb[k-1].ld && (k < LDAVAIL);
      end
    end
  end

endmodule

// File: rtl/m_hazard_unit.sv
// Scoreboard of in-flight register writes driving forwarding selects and
// load-use stalls for the instruction in ID.
module m_hazard_unit
  import pkg_pipe::*;
#(
  parameter int unsigned REGW    = 5,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned LDAVAIL = 3,
  parameter int unsigned SELW    = 2
) (
  input  logic                   w_clk,
  input  logic                   w_rst_n,
  input  logic                   w_id_valid,
  input  logic [NSRC*REGW-1:0]   w_id_src,
  input  logic [NSRC-1:0]        w_id_use,
  input  logic [REGW-1:0]        w_id_rd,
  input  logic                   w_id_we,
  input  logic                   w_id_ld,
  input  logic                   w_flush,
  output logic                   w_stall,
  output logic [NSRC*SELW-1:0]   w_fwd_sel,
  output logic [(2**REGW)-1:0]   w_busy,
  output logic [31:0]            r_issue_cnt,
  output logic [31:0]            r_stall_cnt
);

  // Index 0 is stage 1 (EX), index STAGES-1 is the retiring stage (WB).
  sb_entry_t [STAGES-1:0] r_sb;
  sb_entry_t              w_new;
  logic [NSRC-1:0]        w_hz;
  logic [NSRC*SELW-1:0]   w_sel_raw;
  logic                   w_insert;

  for (genvar i = 0; i < NSRC; i++) begin : g_match
    m_fwd_match #(
      .REGW    (REGW),
      .STAGES  (STAGES),
      .LDAVAIL (LDAVAIL),
      .SELW    (SELW)
    ) u_match (
      .i_sb     (r_sb),
      .i_src    (w_id_src[i*REGW +: REGW]),
      .i_use    (w_id_use[i]),
      .o_sel    (w_sel_raw[i*SELW +: SELW]),
      .o_hazard (w_hz[i])
    );
  end

  assign w_stall   = w_id_valid & (|w_hz) & ~w_flush;
  assign w_fwd_sel = w_stall ? '0 : w_sel_raw;
  assign w_insert  = w_id_valid & ~w_stall & ~w_flush;

  // Entry entering stage 1: the ID instruction or a bubble.
  always_comb begin
    w_new       = '0;
    w_new.valid = w_insert;
    w_new.rd    = RD_MAXW'(w_id_rd);
    w_new.we    = w_id_we;
    w_new.ld    = w_id_ld;
  end

  // Pending-write bitmap; register 0 is never reported.
  always_comb begin
    w_busy = '0;
    for (int unsigned r = 1; r < (2**REGW); r++) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (r_sb[k].valid && r_sb[k].we && (r_sb[k].rd == RD_MAXW'(r)))
          w_busy[r] = 1'b1;
      end
    end
  end

  // Scoreboard shift register: every stage advances each cycle.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_sb <= '0;
    else          r_sb <= {r_sb[STAGES-2:0], w_new};
  end

  // Issue and stall counters, wrapping naturally at 32 bits.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_insert) r_issue_cnt <= r_issue_cnt + 32'd1;
      if (w_stall)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_m_hazard_unit.sv
// Randomised and directed bench for m_hazard_unit with a queue-based model.
module tb_m_hazard_unit;

  localparam int REGW = 5, NSRC = 2, STAGES = 3, LDAVAIL = 3, SELW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [9:0]  id_src = '0;
  logic [1:0]  id_use = '0;
  logic [4:0]  id_rd = '0;
  logic        id_we = 1'b0;
  logic        id_ld = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [31:0] busy;
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;

  m_hazard_unit #(
    .REGW(REGW), .NSRC(NSRC), .STAGES(STAGES), .LDAVAIL(LDAVAIL), .SELW(SELW)
  ) dut (
    .w_clk(clk), .w_rst_n(rst_n), .w_id_valid(id_valid), .w_id_src(id_src),
    .w_id_use(id_use), .w_id_rd(id_rd), .w_id_we(id_we), .w_id_ld(id_ld),
    .w_flush(flush), .w_stall(stall), .w_fwd_sel(fwd_sel), .w_busy(busy),
    .r_issue_cnt(issue_cnt), .r_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history of what entered stage 1, youngest first.
  typedef struct { bit v; int rd; bit we; bit ld; } rec_t;
  rec_t pipe[$];
  int unsigned m_ic = 0, m_sc = 0;
  rec_t pend_rec;
  bit   pend_stall;

  typedef struct { bit st; logic [3:0] fwd; logic [31:0] busy; logic [31:0] ic; logic [31:0] sc; } exp_t;
  exp_t sbq[$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Age (1 = youngest) of the most recent in-flight writer of src, 0 if none.
  function automatic int youngest(int src, bit u);
    if (!u || src == 0) return 0;
    for (int j = 0; j < pipe.size(); j++)
      if (pipe[j].v && pipe[j].we && pipe[j].rd == src) return j + 1;
    return 0;
  endfunction

  task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] u,
                       input int rd, input bit we, input bit ld, input bit fl);
    exp_t e;
    int a0, a1;
    bit hz;
    id_valid = v; id_src = {5'(s1), 5'(s0)}; id_use = u;
    id_rd = 5'(rd); id_we = we; id_ld = ld; flush = fl;
    #1;
    a0 = youngest(s0, u[0]);
    a1 = youngest(s1, u[1]);
    hz = (a0 != 0 && pipe[a0-1].ld && a0 < LDAVAIL) ||
         (a1 != 0 && pipe[a1-1].ld && a1 < LDAVAIL);
    e.st   = v && hz && !fl;
    e.fwd  = e.st ? 4'd0 : {2'(a1), 2'(a0)};
    e.busy = '0;
    for (int r = 1; r < 32; r++)
      foreach (pipe[j]) if (pipe[j].v && pipe[j].we && pipe[j].rd == r) e.busy[r] = 1'b1;
    e.ic = m_ic;
    e.sc = m_sc;
    sbq.push_back(e);
    pend_rec   = '{v: v && !e.st && !fl, rd: rd, we: we, ld: ld};
    pend_stall = e.st;
  endtask

  task automatic tick();
    @(posedge clk);
    pipe.push_front(pend_rec);
    if (pipe.size() > STAGES) void'(pipe.pop_back());
    if (pend_rec.v) m_ic++;
    if (pend_stall) m_sc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
      tick();
    end
  endtask

  // Monitor: outputs are combinational, so every cycle carries one result.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("stall", 32'(stall), 32'(e.st));
      check("fwd_sel", 32'(fwd_sel), 32'(e.fwd));
      check("busy", busy, e.busy);
      check("issue_cnt", issue_cnt, e.ic);
      check("stall_cnt", stall_cnt, e.sc);
    end
  end

  int unsigned base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd", 32'(fwd_sel), 0);
    check("rst_busy", busy, 0);
    check("rst_issue", issue_cnt, 0);
    rst_n = 1'b1;
    idle(10);
    check("idle_issue", issue_cnt, 0);
    check("idle_stall", stall_cnt, 0);

    // ADDI $9,$0,1 then ADD $12,$9,$0 then reader of $9
    drive(1, 0, 0, 2'b01, 9, 1, 0, 0); tick();
    drive(1, 9, 0, 2'b11, 12, 1, 0, 0);
    check("addi_fwd1", 32'(fwd_sel[1:0]), 1);
    check("addi_nostall", 32'(stall), 0);
    tick();
    drive(1, 9, 0, 2'b01, 13, 1, 0, 0);
    check("addi_fwd2", 32'(fwd_sel[1:0]), 2);
    tick();
    idle(3);

    // LW $11,0($10) then ADD $12,$12,$11
    base = stall_cnt;
    drive(1, 10, 0, 2'b01, 11, 1, 1, 0); tick();
    drive(1, 12, 11, 2'b11, 12, 1, 0, 0); check("ldu_st1", 32'(stall), 1); tick();
    drive(1, 12, 11, 2'b11, 12, 1, 0, 0); check("ldu_st2", 32'(stall), 1); tick();
    drive(1, 12, 11, 2'b11, 12, 1, 0, 0);
    check("ldu_release", 32'(stall), 0);
    check("ldu_fwd3", 32'(fwd_sel[3:2]), 3);
    tick();
    check("ldu_stallcnt", stall_cnt - base, 2);
    idle(3);

    // Two writers of $9; then writer of $0 and reader of $0
    drive(1, 0, 0, 2'b01, 9, 1, 1, 0); tick();
    drive(1, 0, 0, 2'b01, 9, 1, 0, 0); tick();
    drive(1, 9, 0, 2'b01, 0, 1, 0, 0);
    check("young_wins", 32'(fwd_sel[1:0]), 1);
    check("young_nostall", 32'(stall), 0);
    tick();
    drive(1, 0, 0, 2'b01, 5, 1, 0, 0);
    check("r0_fwd", 32'(fwd_sel[1:0]), 0);
    check("r0_busy", 32'(busy[0]), 0);
    tick();
    idle(3);

    // Load-use hazard with flush in the same cycle
    drive(1, 0, 0, 2'b01, 11, 1, 1, 0); tick();
    base = issue_cnt;
    drive(1, 11, 0, 2'b01, 12, 1, 0, 1);
    check("flush_nostall", 32'(stall), 0);
    tick();
    check("flush_issue", issue_cnt - base, 0);
    check("flush_bubble", 32'(busy[12]), 0);
    idle(3);

    // Asynchronous reset with a load in stage 1
    drive(1, 0, 0, 2'b01, 11, 1, 1, 0); tick();
    check("pre_rst_busy", 32'(busy[11]), 1);
    rst_n = 1'b0;
    pipe.delete(); m_ic = 0; m_sc = 0;
    #1;
    check("async_busy", busy, 0);
    check("async_issue", issue_cnt, 0);
    #1 rst_n = 1'b1;
    drive(1, 11, 0, 2'b01, 12, 1, 0, 0);
    check("post_rst_fwd", 32'(fwd_sel), 0);
    check("post_rst_stall", 32'(stall), 0);
    tick();

    // Randomised traffic over a small register set to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(9, 0) < 8, $urandom_range(7, 0), $urandom_range(7, 0),
            2'($urandom_range(3, 0)), $urandom_range(7, 0), 1'($urandom_range(1, 0)),
            $urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
